// File: rtl/si_link_pkg.sv
// Shared SI-TT link definitions: header byte constants and the framing FSM state type.
// Used by both the transmit-side header generator and the receive-side parser.
package si_link_pkg;

   // Multi-byte constants are stored so that their low byte is the first byte on the wire.
   localparam logic [15:0] ETHERTYPE_BYTES = 16'h9B80;
   localparam logic [15:0] MAGIC_SI        = 16'h4953;
   localparam logic [15:0] MAGIC_TT        = 16'h5454;
   localparam logic [7:0]  HDR_VERSION     = 8'h00;
   localparam logic [7:0]  HDR_TYPE        = 8'h00;
   localparam int          HEADER_WORDS    = 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HDR0    = 2'd1,
      HDR1    = 2'd2,
      PAYLOAD = 2'd3
   } state_t;

   // Reorders a MAC address so that its most significant byte lands in the lowest byte lane.
   function automatic logic [47:0] mac_to_wire(input logic [47:0] mac);
      logic [47:0] r;
      for (int b = 0; b < 6; b++) begin
         r[8*b +: 8] = mac[8*(5-b) +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/si_header_generator_if.sv
// AXI4-Stream bundle used on both sides of the SI-TT header generator.
interface si_header_generator_if #(
   parameter int DATA_WIDTH = 128,
   parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8
);
   logic                  tvalid;
   logic                  tready;
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tlast;
   logic [KEEP_WIDTH-1:0] tkeep;

   modport master (output tvalid, tdata, tlast, tkeep, input tready);
   modport slave  (input tvalid, tdata, tlast, tkeep, output tready);
endinterface

// File: rtl/si_header_word_builder.sv
// Combinational builder for the two 128-bit SI-TT header words.
// Word 0 carries the MACs, EtherType and "SI" magic; word 1 the "TT" magic and sequence number.
module si_header_word_builder
   import si_link_pkg::*;
(
   input  logic [47:0]  dst_mac_i,
   input  logic [47:0]  src_mac_i,
   input  logic [31:0]  seq_i,
   input  logic         word_idx_i,
   output logic [127:0] word_o
);

   logic [47:0] dst_wire;
   logic [47:0] src_wire;

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_mac_bytes
         assign dst_wire[8*gi +: 8] = dst_mac_i[8*(5-gi) +: 8];
         assign src_wire[8*gi +: 8] = src_mac_i[8*(5-gi) +: 8];
      end
   endgenerate

   always_comb begin
      if (!word_idx_i) begin
         word_o = {MAGIC_SI, ETHERTYPE_BYTES, src_wire, dst_wire};
      end else begin
         word_o = {32'h0000_0000, seq_i, 32'h0000_0000, HDR_TYPE, HDR_VERSION, MAGIC_TT};
      end
   end

endmodule

// File: rtl/si_header_generator.sv
// Prepends the 32-byte SI-TT header to each 128-bit AXI4-Stream payload packet and keeps the
// packet sequence number. Define SI_HEADER_GEN_SPLIT_EN to cut packets at MAX_PAYLOAD_WORDS.
module si_header_generator
   import si_link_pkg::*;
#(
   parameter int DATA_WIDTH        = 128,
   parameter int KEEP_WIDTH        = (DATA_WIDTH + 7) / 8,
   parameter int MAX_PAYLOAD_WORDS = 88
) (
   input  logic                 clk,
   input  logic                 rst,
   si_header_generator_if.slave  s_axis,
   si_header_generator_if.master m_axis,
   input  logic [47:0]          dst_mac,
   input  logic [47:0]          src_mac,
   output logic [31:0]          sequence_o
);

   if (DATA_WIDTH != 128) begin : g_bad_data_width
      $error("si_header_generator: DATA_WIDTH must be 128");
   end
   if (KEEP_WIDTH != DATA_WIDTH / 8) begin : g_bad_keep_width
      $error("si_header_generator: KEEP_WIDTH must be DATA_WIDTH/8");
   end
   if (MAX_PAYLOAD_WORDS < 1 || MAX_PAYLOAD_WORDS > 1023) begin : g_bad_max_words
      $error("si_header_generator: MAX_PAYLOAD_WORDS must be in 1..1023");
   end

   state_t       state_q;
   logic [47:0]  dst_q;
   logic [47:0]  src_q;
   logic [31:0]  seq_q;
   logic [31:0]  seq_d;
   logic [127:0] hdr_word;
   logic         split_now;
   logic         beat_done;

`ifdef SI_HEADER_GEN_SPLIT_EN
   logic [9:0]   word_cnt_q;
   assign split_now = (word_cnt_q == 10'(MAX_PAYLOAD_WORDS - 1));
`else
   assign split_now = 1'b0;
`endif

   assign seq_d      = seq_q + 32'd1;
   assign beat_done  = s_axis.tvalid && m_axis.tready;
   assign sequence_o = seq_q;

   si_header_word_builder u_builder (
      .dst_mac_i  (dst_q),
      .src_mac_i  (src_q),
      .seq_i      (seq_q),
      .word_idx_i (state_q == HDR1),
      .word_o     (hdr_word)
   );

   // Header beats come from registered state; payload beats are a zero-latency pass-through.
   always_comb begin
      m_axis.tvalid = 1'b0;
      m_axis.tdata  = hdr_word;
      m_axis.tkeep  = '1;
      m_axis.tlast  = 1'b0;
      s_axis.tready = 1'b0;
      unique case (state_q)
         HDR0, HDR1: m_axis.tvalid = 1'b1;
         PAYLOAD: begin
            m_axis.tvalid = s_axis.tvalid;
            m_axis.tdata  = s_axis.tdata;
            m_axis.tkeep  = s_axis.tkeep;
            m_axis.tlast  = s_axis.tlast | split_now;
            s_axis.tready = m_axis.tready;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         dst_q      <= '0;
         src_q      <= '0;
         seq_q      <= '0;
`ifdef SI_HEADER_GEN_SPLIT_EN
         word_cnt_q <= '0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (s_axis.tvalid) begin
                  dst_q   <= dst_mac;
                  src_q   <= src_mac;
                  state_q <= HDR0;
               end
            end
            HDR0: begin
               if (m_axis.tready) state_q <= HDR1;
            end
            HDR1: begin
               if (m_axis.tready) begin
                  state_q    <= PAYLOAD;
`ifdef SI_HEADER_GEN_SPLIT_EN
                  word_cnt_q <= '0;
`endif
               end
            end
            PAYLOAD: begin
               if (beat_done) begin
                  if (s_axis.tlast) begin
                     seq_q   <= seq_d;
                     state_q <= IDLE;
                  end else if (split_now) begin
                     // Forced cut: next header reuses the MACs latched for this packet.
                     seq_q   <= seq_d;
                     state_q <= HDR0;
                  end
`ifdef SI_HEADER_GEN_SPLIT_EN
                  word_cnt_q <= word_cnt_q + 10'd1;
`endif
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
